// File: rtl/sobel_window_gen_if.sv
// Pixel-stream-in / 3x3-window-out bundle for sobel_window_gen.
// The master side drives the pixels; the slave side (the window generator) drives the windows.
interface sobel_window_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  done_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] d0_o, d1_o, d2_o;
    logic [DATA_WIDTH-1:0] d3_o, d4_o, d5_o;
    logic [DATA_WIDTH-1:0] d6_o, d7_o, d8_o;
    logic                  done_o;

    modport master (
        output done_i, data_i,
        input  d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o
    );

    modport slave (
        input  done_i, data_i,
        output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Builds a registered 3x3 neighbourhood from a raster pixel stream using two line buffers.
// A window is flagged valid only when it lies fully inside the image (no border padding).
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    sobel_window_gen_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win [9];
    logic [DATA_WIDTH-1:0] up1, up2;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  interior;
    logic                  done_q;

    always_comb begin
        up1      = lb1[col];
        up2      = lb2[col];
        interior = (row >= RW'(2)) && (col >= CW'(2));
    end

    // Line buffers are never reset; each write pushes the column one row further up.
    always_ff @(posedge clk) begin
        if (!rst && bus.done_i) begin
            lb2[col] <= up1;
            lb1[col] <= bus.data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
        end else if (bus.done_i) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= up2;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= up1;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.data_i;
            done_q <= interior;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bus.d0_o   = win[0];
    assign bus.d1_o   = win[1];
    assign bus.d2_o   = win[2];
    assign bus.d3_o   = win[3];
    assign bus.d4_o   = win[4];
    assign bus.d5_o   = win[5];
    assign bus.d6_o   = win[6];
    assign bus.d7_o   = win[7];
    assign bus.d8_o   = win[8];
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 5x4 instance and a 3x3 instance share clk/rst.
// Expected windows are cut from a model image held by the bench.
module tb_sobel_window_gen;
    typedef struct packed {
        logic        valid;
        logic        chk;
        logic [71:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_window_gen_if #(.DATA_WIDTH(8)) bus0 ();
    sobel_window_gen_if #(.DATA_WIDTH(8)) bus1 ();

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .DATA_WIDTH(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_WIDTH(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pc0 = 0;
    int pc1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    int mr[2];
    int mc[2];
    int img_w[2] = '{5, 3};
    int img_h[2] = '{4, 3};
    logic [7:0] img [2][4][5];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] win_of(input int s, input int r, input int c);
        return {img[s][r-2][c-2], img[s][r-2][c-1], img[s][r-2][c],
                img[s][r-1][c-2], img[s][r-1][c-1], img[s][r-1][c],
                img[s][r][c-2],   img[s][r][c-1],   img[s][r][c]};
    endfunction

    task automatic drive(input int s, input logic [7:0] px);
        exp_t e;
        int r, c;
        @(negedge clk);
        rst = 1'b0;
        bus0.done_i = (s == 0);
        bus1.done_i = (s == 1);
        bus0.data_i = px;
        bus1.data_i = px;
        r = mr[s];
        c = mc[s];
        img[s][r][c] = px;
        e.valid = (r >= 2) && (c >= 2);
        e.chk   = e.valid;
        e.win   = e.valid ? win_of(s, r, c) : '0;
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        if (c == img_w[s] - 1) begin
            mc[s] = 0;
            mr[s] = (r == img_h[s] - 1) ? 0 : r + 1;
        end else begin
            mc[s] = c + 1;
        end
    endtask

    task automatic stall(input int s);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        bus0.done_i = 1'b0;
        bus1.done_i = 1'b0;
        bus0.data_i = 8'hA5;
        bus1.data_i = 8'hA5;
        e.valid = 1'b0;
        e.chk   = 1'b0;
        e.win   = '0;
        if (s == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0;
            bus0.done_i = 1'b0;
            bus1.done_i = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        e.valid = 1'b0;
        e.chk   = 1'b1;
        e.win   = '0;
        repeat (n) begin
            @(negedge clk);
            rst = 1'b1;
            bus0.done_i = 1'b1;
            bus1.done_i = 1'b1;
            bus0.data_i = 8'hFF;
            bus1.data_i = 8'hFF;
            q0.push_back(e);
            q1.push_back(e);
        end
        mr = '{0, 0};
        mc = '{0, 0};
    endtask

    always begin : mon0
        exp_t e;
        logic [71:0] w;
        @(posedge clk);
        #1;
        w = {bus0.d0_o, bus0.d1_o, bus0.d2_o, bus0.d3_o, bus0.d4_o,
             bus0.d5_o, bus0.d6_o, bus0.d7_o, bus0.d8_o};
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("done0", {71'd0, bus0.done_o}, {71'd0, e.valid});
            if (e.chk) check("win0", w, e.win);
        end else begin
            check("idle0", {71'd0, bus0.done_o}, '0);
        end
        if (bus0.done_o) pc0++;
    end

    always begin : mon1
        exp_t e;
        logic [71:0] w;
        @(posedge clk);
        #1;
        w = {bus1.d0_o, bus1.d1_o, bus1.d2_o, bus1.d3_o, bus1.d4_o,
             bus1.d5_o, bus1.d6_o, bus1.d7_o, bus1.d8_o};
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("done1", {71'd0, bus1.done_o}, {71'd0, e.valid});
            if (e.chk) check("win1", w, e.win);
        end else begin
            check("idle1", {71'd0, bus1.done_o}, '0);
        end
        if (bus1.done_o) pc1++;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        bus0.done_i = 1'b0;
        bus1.done_i = 1'b0;
        bus0.data_i = '0;
        bus1.data_i = '0;
        mr = '{0, 0};
        mc = '{0, 0};

        // Reset held with valid input: outputs must stay zero.
        do_reset(4);

        // 3x3 frame 1..9: single window on pixel 9.
        base = pc1;
        for (int p = 1; p <= 9; p++) drive(1, 8'(p));
        idle(2);
        check("s1_pulses", 72'(pc1 - base), 72'd1);

        // 5x4 frame, value r*5+c+1.
        base = pc0;
        for (int p = 1; p <= 20; p++) drive(0, 8'(p));
        idle(2);
        check("s2_pulses", 72'(pc0 - base), 72'd6);

        // Same frame with stalls mid-row and at the row 2/3 boundary.
        base = pc0;
        for (int p = 1; p <= 20; p++) begin
            drive(0, 8'(p));
            if (p == 12) repeat (3) stall(0);
            if (p == 15) repeat (2) stall(0);
        end
        idle(2);
        check("s3_pulses", 72'(pc0 - base), 72'd6);

        // Two back-to-back frames, second offset by 100.
        base = pc0;
        for (int p = 1; p <= 20; p++) drive(0, 8'(p));
        for (int p = 1; p <= 20; p++) drive(0, 8'(p + 100));
        idle(2);
        check("s4_pulses", 72'(pc0 - base), 72'd12);

        // Reset after pixel 14, then a fresh frame.
        base = pc0;
        for (int p = 1; p <= 14; p++) drive(0, 8'(p));
        do_reset(2);
        for (int p = 1; p <= 20; p++) drive(0, 8'(p));
        idle(2);
        check("s5_pulses", 72'(pc0 - base), 72'd8);

        check("q0_drain", 72'(q0.size()), 72'd0);
        check("q1_drain", 72'(q1.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
